passcoder_calc_seq: RTL and testbench

//  Multi-cycle, parametrised BCD calculator core for the passcoder datapath: takes two DIGITS-digit BCD operands
//  and a 3-bit op, computes add/sub/mul/div/(pow) on an iterative binary datapath, returns a BCD result.

---
 rtl/passcoder_calc_seq_pkg.sv | 41 ++++
 rtl/passcoder_calc_seq_if.sv | 29 ++
 rtl/passcoder_calc_seq_bin2bcd.sv | 64 ++++++
 rtl/passcoder_calc_seq.sv | 327 ++++++++++++++++++++++++++++++++
 tb/tb_passcoder_calc_seq.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/passcoder_calc_seq_pkg.sv
// Shared definitions for the passcoder BCD calculator.
//   - op codes (OP_ADD .. OP_POW)
//   - sequencer state encoding
//   - calc_w(): binary operand width for a DIGITS-digit BCD operand
//   - op_valid(): op code legality; op 100 is legal only when PASSCODER_POW_EN is defined
package passcoder_calc_seq_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_MUL = 3'b010;
   localparam logic [2:0] OP_DIV = 3'b011;
   localparam logic [2:0] OP_POW = 3'b100;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_EXEC = 3'd2,
      ST_CONV = 3'd3,
      ST_DONE = 3'd4
   } calc_state_t;

   // ceil(log2(10**digits))
   function automatic int calc_w(input int digits);
      longint p;
      int     w;
      p = 1;
      w = 0;
      for (int i = 0; i < digits; i++) p = p * 10;
      while ((longint'(1) << w) < p) w++;
      return w;
   endfunction

   function automatic logic op_valid(input logic [2:0] op);
`ifdef PASSCODER_POW_EN
      return (op <= OP_POW);
`else
      return (op <= OP_DIV);
`endif
   endfunction

endpackage

// File: rtl/passcoder_calc_seq_if.sv
// Request/response bundle of the passcoder calculator.
//   master : keypad/operand side (drives start, op, a_bcd, b_bcd)
//   slave  : calculator core (drives busy, done, result_bcd, rem_bcd, neg, err, led_signal)
// Parameter DIGITS sets the BCD operand width (4*DIGITS bits) and result width (8*DIGITS bits).
interface passcoder_calc_seq_if #(
   parameter int DIGITS = 2
);
   logic                  start;
   logic [2:0]            op;
   logic [4*DIGITS-1:0]   a_bcd;
   logic [4*DIGITS-1:0]   b_bcd;
   logic                  busy;
   logic                  done;
   logic [8*DIGITS-1:0]   result_bcd;
   logic [4*DIGITS-1:0]   rem_bcd;
   logic                  neg;
   logic                  err;
   logic                  led_signal;

   modport master (
      output start, op, a_bcd, b_bcd,
      input  busy, done, result_bcd, rem_bcd, neg, err, led_signal
   );

   modport slave (
      input  start, op, a_bcd, b_bcd,
      output busy, done, result_bcd, rem_bcd, neg, err, led_signal
   );
endinterface

// File: rtl/passcoder_calc_seq_bin2bcd.sv
// Sequential double-dabble binary-to-BCD converter.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       loads bin_in and begins conversion (restarts if already running)
//   bin_in      IN_W-bit binary value
//   done        one-cycle pulse IN_W cycles after the start edge; bcd_out valid from then on
//   bcd_out     OUT_DIGITS packed BCD digits, held until the next start
module passcoder_calc_seq_bin2bcd #(
   parameter int IN_W       = 14,
   parameter int OUT_DIGITS = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [IN_W-1:0]         bin_in,
   output logic                    done,
   output logic [4*OUT_DIGITS-1:0] bcd_out
);
   localparam int CW = $clog2(IN_W + 1);

   logic [IN_W-1:0]         bin_q, bin_d;
   logic [4*OUT_DIGITS-1:0] bcd_q, bcd_d, bcd_adj;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    done_q, done_d;

   always_comb begin
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      bcd_adj = bcd_q;
      for (int i = 0; i < OUT_DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
      if (start) begin
         bin_d = bin_in;
         bcd_d = '0;
         cnt_d = CW'(IN_W);
      end else if (cnt_q != '0) begin
         // adjust-then-shift: the binary MSB enters the BCD LSB
         {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
         cnt_d  = cnt_q - CW'(1);
         done_d = (cnt_q == CW'(1));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_q  <= '0;
         bcd_q  <= '0;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         bin_q  <= bin_d;
         bcd_q  <= bcd_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign done    = done_q;
   assign bcd_out = bcd_q;

endmodule

// File: rtl/passcoder_calc_seq.sv
// Multi-cycle BCD calculator core: two DIGITS-digit BCD operands, op add/sub/mul/div(/pow),
// iterative binary datapath, BCD result plus remainder.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (aborts any operation, no done pulse)
//   bus (slave) start/op/a_bcd/b_bcd in; busy/done/result_bcd/rem_bcd/neg/err/led_signal out
// Build option: PASSCODER_POW_EN defined -> op 100 computes A**B; otherwise op 100 is invalid.
//
// state | meaning
// IDLE  | waiting for start; outputs hold last result
// LOAD  | DIGITS cycles of Horner BCD->binary on A and B; operand/op checks at the end
// EXEC  | arithmetic: add/sub 1 cycle, mul/div W cycles, pow B multiplies of W cycles
// CONV  | double-dabble of result and remainder (RW cycles after the launch edge)
// DONE  | one-cycle done pulse, result valid
module passcoder_calc_seq
   import passcoder_calc_seq_pkg::*;
#(
   parameter int DIGITS = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   passcoder_calc_seq_if.slave bus
);
   localparam int W  = calc_w(DIGITS);
   localparam int RW = 2 * W;
   localparam int XW = RW + W;
   localparam int BW = 4 * DIGITS;
   localparam int SW = $clog2(W + 1);
   localparam int LW = $clog2(DIGITS + 1);
   localparam logic [XW-1:0] LIMIT = XW'(10 ** (2 * DIGITS) - 1);

   calc_state_t       state_q, state_d;
   logic [2:0]        op_q, op_d;
   logic [BW-1:0]     a_sh_q, a_sh_d, b_sh_q, b_sh_d;
   logic [LW-1:0]     load_cnt_q, load_cnt_d;
   logic              bad_q, bad_d;
   logic [W-1:0]      a_q, a_d, b_q, b_d;
   logic [XW-1:0]     mcand_q, mcand_d;
   logic [W-1:0]      mplier_q, mplier_d;
   logic [XW-1:0]     prod_q, prod_d;
   logic [SW-1:0]     step_q, step_d;
   logic [W-1:0]      div_r_q, div_r_d;
   logic [W-1:0]      quo_q, quo_d;
`ifdef PASSCODER_POW_EN
   logic [W-1:0]      pow_cnt_q, pow_cnt_d;
`endif
   logic [2*BW-1:0]   result_q, result_d;
   logic [BW-1:0]     rem_q, rem_d;
   logic              neg_q, neg_d;
   logic              err_q, err_d;
   logic              led_q;

   logic [3:0]        dig_a, dig_b;
   logic [XW-1:0]     prod_nx;
   logic [W:0]        r_sh;
   logic              div_ge;
   logic [W-1:0]      r_nx, q_nx;
   logic              exec_fin;
   logic [XW-1:0]     exec_val;
   logic [W-1:0]      exec_rem;
   logic              conv_start;
   logic [RW-1:0]     conv_res_bin, conv_rem_bin;
   logic              res_done, rem_done;
   logic [2*BW-1:0]   res_bcd;
   logic [BW-1:0]     rem_bcd_c;

   assign dig_a        = a_sh_q[BW-1 -: 4];
   assign dig_b        = b_sh_q[BW-1 -: 4];
   assign conv_res_bin = exec_val[RW-1:0];
   assign conv_rem_bin = RW'(exec_rem);

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      a_sh_d     = a_sh_q;
      b_sh_d     = b_sh_q;
      load_cnt_d = load_cnt_q;
      bad_d      = bad_q;
      a_d        = a_q;
      b_d        = b_q;
      mcand_d    = mcand_q;
      mplier_d   = mplier_q;
      prod_d     = prod_q;
      step_d     = step_q;
      div_r_d    = div_r_q;
      quo_d      = quo_q;
`ifdef PASSCODER_POW_EN
      pow_cnt_d  = pow_cnt_q;
`endif
      result_d   = result_q;
      rem_d      = rem_q;
      neg_d      = neg_q;
      err_d      = err_q;
      exec_fin   = 1'b0;
      exec_val   = '0;
      exec_rem   = '0;
      conv_start = 1'b0;
      prod_nx    = prod_q + (mplier_q[0] ? mcand_q : '0);
      r_sh       = {div_r_q, quo_q[W-1]};
      div_ge     = (r_sh >= {1'b0, b_q});
      r_nx       = div_ge ? W'(r_sh - {1'b0, b_q}) : r_sh[W-1:0];
      q_nx       = {quo_q[W-2:0], div_ge};

      unique case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d    = ST_LOAD;
               op_d       = bus.op;
               a_sh_d     = bus.a_bcd;
               b_sh_d     = bus.b_bcd;
               load_cnt_d = LW'(DIGITS - 1);
               bad_d      = 1'b0;
               a_d        = '0;
               b_d        = '0;
               neg_d      = 1'b0;
               err_d      = 1'b0;
               rem_d      = '0;
            end
         end

         ST_LOAD: begin
            // invalid digits may wrap here; they are flagged and the value discarded
            a_d        = a_q * W'(10) + W'(dig_a);
            b_d        = b_q * W'(10) + W'(dig_b);
            a_sh_d     = a_sh_q << 4;
            b_sh_d     = b_sh_q << 4;
            bad_d      = bad_q | (dig_a > 4'd9) | (dig_b > 4'd9);
            load_cnt_d = load_cnt_q - LW'(1);
            // EXEC operands are set up from the freshly converted values so the
            // first iteration runs in the first EXEC cycle
            mcand_d    = XW'(a_d);
            mplier_d   = b_d;
            prod_d     = '0;
            step_d     = SW'(W - 1);
            div_r_d    = '0;
            quo_d      = a_d;
`ifdef PASSCODER_POW_EN
            pow_cnt_d  = b_d;
            if (op_q == OP_POW) begin
               mcand_d  = XW'(1);
               mplier_d = a_d;
            end
`endif
            if (load_cnt_q == '0) begin
               if (bad_d || !op_valid(op_q) || ((op_q == OP_DIV) && (b_d == '0))) begin
                  state_d  = ST_DONE;
                  err_d    = 1'b1;
                  result_d = '0;
                  rem_d    = '0;
               end else begin
                  state_d = ST_EXEC;
               end
            end
         end

         ST_EXEC: begin
            step_d = step_q - SW'(1);
            case (op_q)
               OP_ADD: begin
                  exec_fin = 1'b1;
                  exec_val = XW'(a_q) + XW'(b_q);
               end
               OP_SUB: begin
                  exec_fin = 1'b1;
                  if (a_q < b_q) begin
                     exec_val = XW'(b_q - a_q);
                     neg_d    = 1'b1;
                  end else begin
                     exec_val = XW'(a_q - b_q);
                  end
               end
               OP_MUL: begin
                  prod_d   = prod_nx;
                  mcand_d  = mcand_q << 1;
                  mplier_d = mplier_q >> 1;
                  if (step_q == '0) begin
                     exec_fin = 1'b1;
                     exec_val = prod_nx;
                  end
               end
               OP_DIV: begin
                  div_r_d = r_nx;
                  quo_d   = q_nx;
                  if (step_q == '0) begin
                     exec_fin = 1'b1;
                     exec_val = XW'(q_nx);
                     exec_rem = r_nx;
                  end
               end
`ifdef PASSCODER_POW_EN
               OP_POW: begin
                  if (pow_cnt_q == '0) begin
                     exec_fin = 1'b1;
                     exec_val = XW'(1);
                  end else begin
                     prod_d   = prod_nx;
                     mcand_d  = mcand_q << 1;
                     mplier_d = mplier_q >> 1;
                     if (step_q == '0) begin
                        // stop after the last multiply, or as soon as the running power overflows
                        if ((prod_nx > LIMIT) || (pow_cnt_q == W'(1))) begin
                           exec_fin = 1'b1;
                           exec_val = prod_nx;
                        end else begin
                           pow_cnt_d = pow_cnt_q - W'(1);
                           mcand_d   = prod_nx;
                           mplier_d  = a_q;
                           prod_d    = '0;
                           step_d    = SW'(W - 1);
                        end
                     end
                  end
               end
`endif
               default: exec_fin = 1'b1;
            endcase
            if (exec_fin) begin
               if (exec_val > LIMIT) begin
                  state_d  = ST_DONE;
                  err_d    = 1'b1;
                  neg_d    = 1'b0;
                  result_d = '0;
                  rem_d    = '0;
               end else begin
                  state_d    = ST_CONV;
                  conv_start = 1'b1;
               end
            end
         end

         ST_CONV: begin
            if (res_done && rem_done) begin
               state_d  = ST_DONE;
               result_d = res_bcd;
               rem_d    = rem_bcd_c;
            end
         end

         ST_DONE: state_d = ST_IDLE;

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         op_q       <= '0;
         a_sh_q     <= '0;
         b_sh_q     <= '0;
         load_cnt_q <= '0;
         bad_q      <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         mcand_q    <= '0;
         mplier_q   <= '0;
         prod_q     <= '0;
         step_q     <= '0;
         div_r_q    <= '0;
         quo_q      <= '0;
`ifdef PASSCODER_POW_EN
         pow_cnt_q  <= '0;
`endif
         result_q   <= '0;
         rem_q      <= '0;
         neg_q      <= 1'b0;
         err_q      <= 1'b0;
         led_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         a_sh_q     <= a_sh_d;
         b_sh_q     <= b_sh_d;
         load_cnt_q <= load_cnt_d;
         bad_q      <= bad_d;
         a_q        <= a_d;
         b_q        <= b_d;
         mcand_q    <= mcand_d;
         mplier_q   <= mplier_d;
         prod_q     <= prod_d;
         step_q     <= step_d;
         div_r_q    <= div_r_d;
         quo_q      <= quo_d;
`ifdef PASSCODER_POW_EN
         pow_cnt_q  <= pow_cnt_d;
`endif
         result_q   <= result_d;
         rem_q      <= rem_d;
         neg_q      <= neg_d;
         err_q      <= err_d;
         led_q      <= err_q;
      end
   end

   passcoder_calc_seq_bin2bcd #(
      .IN_W       (RW),
      .OUT_DIGITS (2 * DIGITS)
   ) u_res_conv (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (conv_start),
      .bin_in  (conv_res_bin),
      .done    (res_done),
      .bcd_out (res_bcd)
   );

   // remainder < 10**DIGITS, so DIGITS output digits never lose information
   passcoder_calc_seq_bin2bcd #(
      .IN_W       (RW),
      .OUT_DIGITS (DIGITS)
   ) u_rem_conv (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (conv_start),
      .bin_in  (conv_rem_bin),
      .done    (rem_done),
      .bcd_out (rem_bcd_c)
   );

   assign bus.busy       = (state_q == ST_LOAD) || (state_q == ST_EXEC) || (state_q == ST_CONV);
   assign bus.done       = (state_q == ST_DONE);
   assign bus.result_bcd = result_q;
   assign bus.rem_bcd    = rem_q;
   assign bus.neg        = neg_q;
   assign bus.err        = err_q;
   assign bus.led_signal = led_q;

endmodule

// File: tb/tb_passcoder_calc_seq.sv
// Scoreboard bench for passcoder_calc_seq (DIGITS=2). Directed vectors push expected
// responses; a monitor pops and compares on every done pulse.
module tb_passcoder_calc_seq;
   import passcoder_calc_seq_pkg::*;

   typedef struct {
      logic [15:0] res;
      logic [7:0]  rem;
      logic        neg;
      logic        err;
      int          lat;
      string       name;
   } exp_t;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   int   cyc;
   int   start_cyc;
   exp_t exp_q[$];

   passcoder_calc_seq_if #(.DIGITS(2)) bus ();

   passcoder_calc_seq #(.DIGITS(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s got=%0h expected=%0h", nm, act, expv);
      end
   endtask

   // monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && bus.done) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_done result=%0h", bus.result_bcd);
            end else begin
               e = exp_q.pop_front();
               chk({e.name, ":result"}, 32'(bus.result_bcd), 32'(e.res));
               chk({e.name, ":rem"},    32'(bus.rem_bcd),    32'(e.rem));
               chk({e.name, ":neg"},    32'(bus.neg),        32'(e.neg));
               chk({e.name, ":err"},    32'(bus.err),        32'(e.err));
               chk({e.name, ":busy"},   32'(bus.busy),       32'(0));
               if (e.lat >= 0) chk({e.name, ":latency"}, 32'(cyc - start_cyc), 32'(e.lat));
               @(negedge clk);
               chk({e.name, ":led"}, 32'(bus.led_signal), 32'(e.err));
            end
         end
      end
   end

   task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] r, input logic [7:0] rm, input logic ng,
                         input logic er, input int lat, input string nm, input bit mid);
      exp_t e;
      int   n;
      bit   busy_drop;
      e.res = r; e.rem = rm; e.neg = ng; e.err = er; e.lat = lat; e.name = nm;
      exp_q.push_back(e);
      @(negedge clk);
      bus.op = op; bus.a_bcd = a; bus.b_bcd = b; bus.start = 1'b1;
      @(posedge clk);
      #1;
      start_cyc = cyc;
      bus.start = 1'b0;
      chk({nm, ":err_clear"}, 32'(bus.err), 32'(0));
      @(posedge clk);
      #1;
      chk({nm, ":led_clear"}, 32'(bus.led_signal), 32'(0));
      busy_drop = 1'b0;
      for (n = 0; n < 100; n++) begin
         @(negedge clk);
         if (bus.done) break;
         if (!bus.busy) busy_drop = 1'b1;
         if (mid && n == 5) begin
            bus.op = OP_ADD; bus.a_bcd = 8'h01; bus.b_bcd = 8'h02; bus.start = 1'b1;
         end else begin
            bus.start = 1'b0;
         end
      end
      bus.start = 1'b0;
      if (n >= 100) begin
         total++;
         bad++;
         $display("FAIL %s:timeout got=no_done expected=done", nm);
         exp_q.delete();
      end
      chk({nm, ":busy_hold"}, 32'(busy_drop), 32'(0));
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      total = 0; bad = 0; cyc = 0; start_cyc = 0;
      rst_n = 1'b0;
      bus.start = 1'b0; bus.op = 3'b000; bus.a_bcd = 8'h00; bus.b_bcd = 8'h00;
      repeat (3) @(negedge clk);
      chk("reset_outputs", 32'({bus.busy, bus.done, bus.neg, bus.err, bus.led_signal,
                                bus.rem_bcd, bus.result_bcd}), 32'(0));
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      run_op(OP_ADD, 8'h01, 8'h02, 16'h0003, 8'h00, 1'b0, 1'b0, 18, "add_01_02", 1'b0);
      run_op(OP_SUB, 8'h57, 8'h25, 16'h0032, 8'h00, 1'b0, 1'b0, 18, "sub_57_25", 1'b0);
      run_op(OP_SUB, 8'h25, 8'h57, 16'h0032, 8'h00, 1'b1, 1'b0, 18, "sub_25_57", 1'b0);
      run_op(OP_ADD, 8'h99, 8'h99, 16'h0198, 8'h00, 1'b0, 1'b0, 18, "add_99_99", 1'b0);
      run_op(OP_MUL, 8'h79, 8'h98, 16'h7742, 8'h00, 1'b0, 1'b0, 24, "mul_79_98", 1'b1);
      repeat (30) @(negedge clk);
      run_op(OP_MUL, 8'h99, 8'h99, 16'h9801, 8'h00, 1'b0, 1'b0, 24, "mul_99_99", 1'b0);
      run_op(OP_DIV, 8'h95, 8'h02, 16'h0047, 8'h01, 1'b0, 1'b0, 24, "div_95_02", 1'b0);
      run_op(OP_DIV, 8'h07, 8'h09, 16'h0000, 8'h07, 1'b0, 1'b0, 24, "div_07_09", 1'b0);
      run_op(OP_DIV, 8'h95, 8'h00, 16'h0000, 8'h00, 1'b0, 1'b1, -1, "div_by_0", 1'b0);
      run_op(OP_ADD, 8'h5A, 8'h01, 16'h0000, 8'h00, 1'b0, 1'b1, -1, "bad_digit", 1'b0);
      run_op(3'b101, 8'h12, 8'h34, 16'h0000, 8'h00, 1'b0, 1'b1, -1, "bad_op_101", 1'b0);
`ifdef PASSCODER_POW_EN
      run_op(OP_POW, 8'h09, 8'h03, 16'h0729, 8'h00, 1'b0, 1'b0, -1, "pow_9_3", 1'b0);
      run_op(OP_POW, 8'h99, 8'h03, 16'h0000, 8'h00, 1'b0, 1'b1, -1, "pow_99_3", 1'b0);
      run_op(OP_POW, 8'h00, 8'h00, 16'h0001, 8'h00, 1'b0, 1'b0, -1, "pow_0_0", 1'b0);
`else
      run_op(OP_POW, 8'h09, 8'h03, 16'h0000, 8'h00, 1'b0, 1'b1, -1, "pow_disabled", 1'b0);
`endif
      run_op(OP_DIV, 8'h95, 8'h02, 16'h0047, 8'h01, 1'b0, 1'b0, 24, "div_pre_rst", 1'b0);

      // reset in the middle of a multiply
      @(negedge clk);
      bus.op = OP_MUL; bus.a_bcd = 8'h79; bus.b_bcd = 8'h98; bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (8) @(negedge clk);
      chk("busy_before_rst", 32'(bus.busy), 32'(1));
      rst_n = 1'b0;
      #1;
      chk("rst_abort_outputs", 32'({bus.busy, bus.done, bus.neg, bus.err, bus.led_signal,
                                    bus.rem_bcd, bus.result_bcd}), 32'(0));
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);

      run_op(OP_MUL, 8'h79, 8'h98, 16'h7742, 8'h00, 1'b0, 1'b0, 24, "mul_after_rst", 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
